// File: rtl/sprite_compositor.sv
// N-channel sprite engine: fetches one bitmap row per sprite each scanline, composites sprites over the background, moves sprites once per frame.
// Latency: vga_rgb is registered one cycle after hpos/vpos/display_on; a line fetch takes 2*NUM_SPRITES cycles after line_start.
// Backpressure: none; line_start while busy is dropped. Optional feature macro: SPRITE_COLLISION_EN (adds the collision port and logic).
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int POS_W       = 10,
  parameter int VEL_W       = 4,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [POS_W-1:0]            hpos,
  input  logic [POS_W-1:0]            vpos,
  input  logic                        display_on,
  input  logic                        line_start,
  input  logic                        frame_tick,
  input  logic [2:0]                  bg_rgb,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_sel,
  input  logic [1:0]                  cfg_field,
  input  logic [POS_W-1:0]            cfg_wdata,
  output logic [2:0]                  rom_sprite,
  output logic [$clog2(SPRITE_H)-1:0] rom_line,
  input  logic [4*SPRITE_W-1:0]       rom_bits,
  output logic                        busy,
  output logic [2:0]                  vga_rgb
`ifdef SPRITE_COLLISION_EN
  ,
  output logic [NUM_SPRITES-1:0]      collision
`endif
);

  localparam int LINE_W = $clog2(SPRITE_H);
  localparam int COL_W  = $clog2(SPRITE_W);
  localparam int ROW_W  = 4 * SPRITE_W;
  // Two spare bits so that x+vx never wraps, even from out-of-range config writes.
  localparam int EXT_W  = POS_W + 2;

  localparam logic signed [EXT_W-1:0] X_LIM   = EXT_W'(X_MAX - SPRITE_W);
  localparam logic signed [EXT_W-1:0] Y_LIM   = EXT_W'(Y_MAX - SPRITE_H);
  localparam logic [VEL_W-1:0]        MIN_VEL = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic [VEL_W-1:0]        MAX_VEL = {1'b0, {(VEL_W-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} fetch_state_t;

  // Sprite registers; velocities hold two's-complement bit patterns.
  logic [POS_W-1:0] x_q  [NUM_SPRITES];
  logic [POS_W-1:0] y_q  [NUM_SPRITES];
  logic [VEL_W-1:0] vx_q [NUM_SPRITES];
  logic [VEL_W-1:0] vy_q [NUM_SPRITES];

  // Line fetch
  fetch_state_t     state_q, state_d;
  logic [2:0]       idx_q;
  logic [POS_W-1:0] target_q;
  logic             last_idx;
  logic [2:0]       fetch_sel;
  logic [POS_W-1:0] fetch_tgt, fetch_y, cur_y, cur_off;
  logic [LINE_W-1:0] line_off;
  logic             in_range;

  // Line buffer and render
  logic [ROW_W-1:0]       row_q   [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] valid_q;
  logic [NUM_SPRITES-1:0] running_q;
  logic [COL_W-1:0]       col_q   [NUM_SPRITES];
  logic [COL_W-1:0]       col_cur [NUM_SPRITES];
  logic [3:0]             pix_dat [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] start, opaque;
  logic [2:0]             rgb_d;

  // Motion
  logic [POS_W+VEL_W-1:0] mot_x [NUM_SPRITES];
  logic [POS_W+VEL_W-1:0] mot_y [NUM_SPRITES];

  // One axis step with edge bounce; returns {new position, new velocity}.
  function automatic logic [POS_W+VEL_W-1:0] bounce(input logic [POS_W-1:0] p,
                                                    input logic [VEL_W-1:0] v,
                                                    input logic signed [EXT_W-1:0] lim);
    logic signed [EXT_W-1:0] np;
    logic [VEL_W-1:0]        nv;
    np = $signed({2'b00, p}) + $signed({{(EXT_W-VEL_W){v[VEL_W-1]}}, v});
    // The most negative velocity has no positive twin; clamp it.
    nv = (v == MIN_VEL) ? MAX_VEL : (VEL_W'(0) - v);
    if (np[EXT_W-1])
      bounce = {{POS_W{1'b0}}, nv};
    else if (np > lim)
      bounce = {lim[POS_W-1:0], nv};
    else
      bounce = {np[POS_W-1:0], v};
  endfunction

  // Fetch FSM next-state and busy flag.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != S_IDLE);
    last_idx = (idx_q == 3'(NUM_SPRITES - 1));
    case (state_q)
      S_IDLE:  if (line_start) state_d = S_ADDR;
      S_ADDR:  state_d = S_DATA;
      S_DATA:  state_d = last_idx ? S_IDLE : S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next ROM address and the hit test for the row arriving this cycle.
  always_comb begin
    fetch_sel = (state_q == S_IDLE) ? 3'd0 : (idx_q + 3'd1);
    fetch_tgt = (state_q == S_IDLE) ? (vpos + POS_W'(1)) : target_q;
    fetch_y   = '0;
    cur_y     = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (fetch_sel == 3'(i)) fetch_y = y_q[i];
      if (idx_q == 3'(i))     cur_y   = y_q[i];
    end
    line_off = fetch_tgt[LINE_W-1:0] - fetch_y[LINE_W-1:0];
    cur_off  = target_q - cur_y;
    in_range = (target_q >= cur_y) && (cur_off < POS_W'(SPRITE_H));
  end

  // Fetch datapath: ROM address registers, row buffers and valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= '0;
      target_q   <= '0;
      rom_sprite <= '0;
      rom_line   <= '0;
      valid_q    <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) row_q[i] <= '0;
    end else begin
      if (state_q == S_IDLE && line_start) begin
        target_q   <= fetch_tgt;
        idx_q      <= '0;
        rom_sprite <= fetch_sel;
        rom_line   <= line_off;
      end
      if (state_q == S_DATA) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (idx_q == 3'(i)) begin
            valid_q[i] <= in_range;
            if (in_range) row_q[i] <= rom_bits;
          end
        end
        if (!last_idx) begin
          idx_q      <= fetch_sel;
          rom_sprite <= fetch_sel;
          rom_line   <= line_off;
        end
      end
    end
  end

  // Per-sprite pixel select and priority composite (lowest index wins).
  always_comb begin
    rgb_d = bg_rgb;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      start[i]   = display_on && valid_q[i] && (hpos == x_q[i]);
      col_cur[i] = start[i] ? '0 : col_q[i];
      pix_dat[i] = row_q[i][4*col_cur[i] +: 4];
      opaque[i]  = (start[i] || running_q[i]) && pix_dat[i][0];
    end
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) rgb_d = pix_dat[i][3:1];
    end
    if (!display_on) rgb_d = 3'b000;
  end

  // Column counters: pixel 0 is shown at the hpos==x cycle, then SPRITE_W-1 more.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) col_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (start[i]) begin
          running_q[i] <= (SPRITE_W > 1);
          col_q[i]     <= COL_W'(1);
        end else if (running_q[i]) begin
          if (col_q[i] == COL_W'(SPRITE_W - 1)) running_q[i] <= 1'b0;
          col_q[i] <= col_q[i] + COL_W'(1);
        end
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vga_rgb <= 3'b000;
    else          vga_rgb <= rgb_d;
  end

  // Candidate motion results for every sprite.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      mot_x[i] = bounce(x_q[i], vx_q[i], X_LIM);
      mot_y[i] = bounce(y_q[i], vy_q[i], Y_LIM);
    end
  end

  // Sprite registers: frame motion first, a same-cycle config write overrides its field.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (frame_tick) begin
          {x_q[i], vx_q[i]} <= mot_x[i];
          {y_q[i], vy_q[i]} <= mot_y[i];
        end
        if (cfg_we && (cfg_sel == 3'(i))) begin
          case (cfg_field)
            2'd0: x_q[i]  <= cfg_wdata;
            2'd1: y_q[i]  <= cfg_wdata;
            2'd2: vx_q[i] <= cfg_wdata[VEL_W-1:0];
            default: vy_q[i] <= cfg_wdata[VEL_W-1:0];
          endcase
        end
      end
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] coll_flags_q;
  logic                   multi_hit;

  // Two or more opaque sprites on the same visible pixel.
  always_comb begin
    multi_hit = display_on && ($countones(opaque) > 1);
  end

  // Sticky flags, published and cleared once per frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_flags_q <= '0;
      collision    <= '0;
    end else if (frame_tick) begin
      collision    <= coll_flags_q;
      coll_flags_q <= '0;
    end else if (multi_hit) begin
      coll_flags_q <= coll_flags_q | opaque;
    end
  end
`endif

endmodule
